// File: rtl/muldiv_unit.sv
// Iterative RV32IM multiply/divide unit: 32 shift-add or restoring-divide steps plus
// one sign-correction cycle, with a START/BUSY/DONE handshake and a fixed 33-cycle latency.
module muldiv_unit (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic        KILL,
    input  logic [4:0]  SELECT,
    input  logic [31:0] DATA1,
    input  logic [31:0] DATA2,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] RESULT
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_ADJUST} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q;
    logic [2:0]  op_q;
    logic [31:0] opa_q, opb_q;
    logic [63:0] acc_q;
    logic [31:0] rem_q;
    logic        neg_q, rem_neg_q, div_zero_q;
    logic        busy_q, done_q;
    logic [31:0] result_q;

    logic        start_ok;
    logic        a_signed, b_signed, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift, div_trial;
    logic [63:0] prod;
    logic [31:0] quot, remr, result_d;

    assign start_ok = START && !KILL && (SELECT[4:3] == 2'b01) && (state_q == S_IDLE);

    // MUL only needs the low word, so it is handled as unsigned.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (SELECT[2:0])
            3'b001, 3'b100, 3'b110: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            3'b011:  a_signed = 1'b1;
            default: ;
        endcase
    end

    assign a_neg = a_signed & DATA1[31];
    assign b_neg = b_signed & DATA2[31];
    assign a_mag = a_neg ? -DATA1 : DATA1;
    assign b_mag = b_neg ? -DATA2 : DATA2;

    // Multiplier sits in acc low half and shifts out as the product shifts in.
    assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opa_q} : 33'd0);
    assign mul_next = {mul_sum, acc_q[31:1]};

    // Dividend bits leave acc low half from the top while quotient bits enter at the bottom.
    assign div_shift = {rem_q, acc_q[31]};
    assign div_trial = div_shift - {1'b0, opb_q};

    // Signed overflow (0x80000000 / -1) falls out naturally from magnitude arithmetic.
    assign prod = neg_q ? -acc_q : acc_q;
    assign quot = div_zero_q ? 32'hFFFF_FFFF : (neg_q ? -acc_q[31:0] : acc_q[31:0]);
    assign remr = rem_neg_q ? -rem_q : rem_q;

    always_comb begin
        result_d = remr;
        case (op_q)
            3'b000:                 result_d = prod[31:0];
            3'b001, 3'b010, 3'b011: result_d = prod[63:32];
            3'b100, 3'b101:         result_d = quot;
            default:                result_d = remr;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (KILL) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (start_ok) state_d = S_CALC;
                S_CALC:   if (cnt_q == 6'd31) state_d = S_ADJUST;
                S_ADJUST: state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (RESET) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge CLK) begin
        // NOTE: every datapath register is reset, so an aborted operation leaves no stale state.
        if (RESET) begin
            cnt_q      <= 6'd0;
            op_q       <= 3'd0;
            opa_q      <= 32'd0;
            opb_q      <= 32'd0;
            acc_q      <= 64'd0;
            rem_q      <= 32'd0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= 32'd0;
        end else begin
            busy_q <= (state_d != S_IDLE);
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        op_q       <= SELECT[2:0];
                        opa_q      <= a_mag;
                        opb_q      <= b_mag;
                        acc_q      <= {32'd0, SELECT[2] ? a_mag : b_mag};
                        rem_q      <= 32'd0;
                        neg_q      <= a_neg ^ b_neg;
                        rem_neg_q  <= a_neg;
                        div_zero_q <= (DATA2 == 32'd0);
                        cnt_q      <= 6'd0;
                    end
                end
                S_CALC: begin
                    cnt_q <= (cnt_q == 6'd31) ? 6'd0 : cnt_q + 6'd1;
                    if (op_q[2]) begin
                        acc_q <= {32'd0, acc_q[30:0], ~div_trial[32]};
                        rem_q <= div_trial[32] ? div_shift[31:0] : div_trial[31:0];
                    end else begin
                        acc_q <= mul_next;
                    end
                end
                S_ADJUST: begin
                    if (!KILL) begin
                        result_q <= result_d;
                        done_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign RESULT = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors push expected result and DONE cycle,
// a negedge monitor pops and compares every DONE.
module tb_muldiv_unit;

    localparam logic [4:0] OP_MUL    = 5'b01000;
    localparam logic [4:0] OP_MULH   = 5'b01001;
    localparam logic [4:0] OP_MULHU  = 5'b01010;
    localparam logic [4:0] OP_MULHSU = 5'b01011;
    localparam logic [4:0] OP_DIV    = 5'b01100;
    localparam logic [4:0] OP_DIVU   = 5'b01101;
    localparam logic [4:0] OP_REM    = 5'b01110;
    localparam logic [4:0] OP_REMU   = 5'b01111;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, start, kill;
    logic [4:0]  select;
    logic [31:0] data1, data2;
    logic        busy, done;
    logic [31:0] result;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [31:0] last_res;

    muldiv_unit dut (
        .CLK(clk), .RESET(reset), .START(start), .KILL(kill), .SELECT(select),
        .DATA1(data1), .DATA2(data2), .BUSY(busy), .DONE(done), .RESULT(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got DONE=1 expected no DONE (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", result, e.res);
                check("done_cycle", cyc, e.due);
            end
        end
    end

    // Called at a negedge; the START edge is the next posedge.
    task automatic issue(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit push);
        start  = 1'b1;
        select = sel;
        data1  = a;
        data2  = b;
        if (push) begin
            sb.push_back('{res: exp, due: cyc + 34});
            last_res = exp;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        @(negedge clk);
        issue(sel, a, b, exp, 1'b1);
        wait_done();
    endtask

    task automatic expect_quiet(input string name, input int ncyc);
        int ndone = 0;
        for (int n = 0; n < ncyc; n++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check(name, ndone, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nbusy;
        reset = 1'b1; start = 1'b0; kill = 1'b0;
        select = 5'd0; data1 = 32'd0; data2 = 32'd0; last_res = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 32'd0);

        // MUL 100*20 with BUSY width measured
        @(negedge clk);
        issue(OP_MUL, 32'd100, 32'd20, 32'h0000_07D0, 1'b1);
        nbusy = 0;
        while (busy && nbusy < 40) begin
            nbusy++;
            @(negedge clk);
        end
        check("busy_cycles", nbusy, 33);
        check("done_with_busy_low", done, 1);

        run_op(OP_MULH,   32'hFFFF_FFF6, 32'hFFFF_FFEC, 32'h0000_0000);
        run_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        run_op(OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        run_op(OP_MULHSU, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF);
        run_op(OP_MUL,    32'h0001_0000, 32'h0001_0003, 32'h0003_0000);
        run_op(OP_MULHU,  32'h0001_0000, 32'h0001_0003, 32'h0000_0001);

        run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op(OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op(OP_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC);
        run_op(OP_REMU, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001);
        run_op(OP_DIV,  32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2);
        run_op(OP_REM,  32'd100, 32'hFFFF_FFF9, 32'h0000_0002);

        run_op(OP_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF);
        run_op(OP_REM,  32'd5, 32'd0, 32'h0000_0005);
        run_op(OP_DIV,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF);
        run_op(OP_REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB);
        run_op(OP_DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF);
        run_op(OP_REMU, 32'd7, 32'd0, 32'h0000_0007);
        run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);

        // Back-to-back: second START lands in the DONE cycle of the first
        @(negedge clk);
        issue(OP_DIVU, 32'd1000, 32'd7, 32'd142, 1'b1);
        wait_done();
        issue(OP_REMU, 32'd1000, 32'd7, 32'd6, 1'b1);
        for (int i = 0; i < 20; i++) begin
            start  = (i % 3 == 0);
            select = OP_MUL;
            data1  = 32'd9;
            data2  = 32'd9;
            @(negedge clk);
        end
        start = 1'b0;
        wait_done();
        expect_quiet("no_extra_done", 40);

        // Invalid SELECT codes are ignored
        @(negedge clk);
        issue(5'b00000, 32'd3, 32'd4, 32'd0, 1'b0);
        check("bad_sel_00000_busy", busy, 0);
        issue(5'b10000, 32'd3, 32'd4, 32'd0, 1'b0);
        check("bad_sel_10000_busy", busy, 0);
        issue(5'b00111, 32'd3, 32'd4, 32'd0, 1'b0);
        check("bad_sel_00111_busy", busy, 0);
        expect_quiet("bad_sel_no_done", 40);

        // KILL together with START in IDLE
        @(negedge clk);
        kill = 1'b1;
        issue(OP_MUL, 32'd3, 32'd4, 32'd0, 1'b0);
        kill = 1'b0;
        check("kill_start_busy", busy, 0);
        expect_quiet("kill_start_no_done", 40);

        // KILL ten cycles into an operation
        @(negedge clk);
        issue(OP_MUL, 32'd3, 32'd4, 32'd0, 1'b0);
        repeat (9) @(negedge clk);
        check("busy_before_kill", busy, 1);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_busy", busy, 0);
        check("kill_result_held", result, last_res);
        expect_quiet("kill_no_done", 40);
        check("kill_result_after", result, last_res);

        // RESET in the middle of an operation
        @(negedge clk);
        issue(OP_DIV, 32'd77, 32'd5, 32'd0, 1'b0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_result", result, 32'd0);
        reset = 1'b0;
        expect_quiet("rst_mid_no_done", 40);

        // Unit still works after the abort
        run_op(OP_MUL, 32'd12, 32'd13, 32'd156);
        repeat (2) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
